// File: rtl/ext_bus_master_seq.sv
// ext_bus_master_seq: sequences fill (write) and verify (read/compare)
// bursts of 32-bit words on an external bus with wait states and timeout.
module ext_bus_master_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        start,
    input  logic        mode,
    input  logic [29:0] base_addr,
    input  logic [15:0] word_count,
    input  logic [31:0] seed,
    output logic [29:0] ext_address,
    output logic [3:0]  ext_byte_enable,
    output logic        ext_read,
    output logic        ext_write,
    output logic [31:0] ext_write_data,
    input  logic        ext_acknowledge,
    input  logic [31:0] ext_read_data,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [15:0] err_count,
    output logic [29:0] first_err_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_mode;
    logic [27:0] r_base;
    logic [15:0] r_count;
    logic [31:0] r_seed;
    logic [15:0] r_idx;
    logic [15:0] r_wait;
    logic [15:0] r_err_count;
    logic [29:0] r_first_err;
    logic        r_timeout;

    logic        w_accept;
    logic        w_issue;
    logic        w_ack;
    logic        w_tmo;
    logic [15:0] w_idx_next;
    logic [29:0] w_addr;
    logic [31:0] w_pattern;
    logic        w_mismatch;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_issue    = (r_state == S_ISSUE);
    assign w_ack      = w_issue && ext_acknowledge;
    assign w_tmo      = w_issue && !ext_acknowledge && (r_wait == LP_TMO_LAST);
    assign w_idx_next = r_idx + 16'd1;
    assign w_addr     = {r_base + {12'd0, r_idx}, 2'b00};
    assign w_pattern  = r_seed + {16'd0, r_idx};
    assign w_mismatch = w_ack && r_mode && (ext_read_data != w_pattern);

    // State register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_state <= S_IDLE;
        else                r_state <= w_next;
    end

    // Next-state and bus/status outputs
    always_comb begin
        w_next          = r_state;
        ext_address     = '0;
        ext_byte_enable = 4'h0;
        ext_read        = 1'b0;
        ext_write       = 1'b0;
        ext_write_data  = '0;
        busy            = 1'b0;
        done            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = (word_count == 16'd0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                busy            = 1'b1;
                ext_address     = w_addr;
                ext_byte_enable = 4'hF;
                ext_read        = r_mode;
                ext_write       = !r_mode;
                ext_write_data  = r_mode ? 32'd0 : w_pattern;
                if (ext_acknowledge) w_next = S_GAP;
                else if (w_tmo)      w_next = S_DONE;
            end
            S_GAP: begin
                busy   = 1'b1;
                w_next = (w_idx_next == r_count) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command capture, word index, wait counter and error tracking
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_mode      <= 1'b0;
            r_base      <= '0;
            r_count     <= '0;
            r_seed      <= '0;
            r_idx       <= '0;
            r_wait      <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_wait <= w_issue ? r_wait + 16'd1 : 16'd0;
            if (w_accept) begin
                r_mode      <= mode;
                r_base      <= base_addr[29:2];
                r_count     <= word_count;
                r_seed      <= seed;
                r_idx       <= '0;
                r_err_count <= '0;
                r_first_err <= '0;
                r_timeout   <= 1'b0;
            end
            if (r_state == S_GAP) r_idx <= w_idx_next;
            if (w_mismatch) begin
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                if (r_err_count == 16'd0)    r_first_err <= w_addr;
            end
            if (w_tmo) r_timeout <= 1'b1;
        end
    end

    assign timeout_err    = r_timeout;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err;

endmodule

// File: tb/tb_ext_bus_master_seq.sv
// tb_ext_bus_master_seq: randomized bus responder plus per-scenario tasks
// checking the sequencer against a transaction-level reference model.
module tb_ext_bus_master_seq;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        start;
    logic        mode;
    logic [29:0] base_addr;
    logic [15:0] word_count;
    logic [31:0] seed;
    logic [29:0] ext_address;
    logic [3:0]  ext_byte_enable;
    logic        ext_read;
    logic        ext_write;
    logic [31:0] ext_write_data;
    logic        ext_acknowledge;
    logic [31:0] ext_read_data;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [15:0] err_count;
    logic [29:0] first_err_addr;

    always #5 clk_clk = ~clk_clk;

    ext_bus_master_seq #(.TIMEOUT_CYCLES(8)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start),
        .mode(mode), .base_addr(base_addr), .word_count(word_count),
        .seed(seed), .ext_address(ext_address),
        .ext_byte_enable(ext_byte_enable), .ext_read(ext_read),
        .ext_write(ext_write), .ext_write_data(ext_write_data),
        .ext_acknowledge(ext_acknowledge), .ext_read_data(ext_read_data),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    int n_pass = 0;
    int n_total = 0;

    // responder controls and logs
    int          dly_fixed = 0;
    bit          noack = 1'b0;
    logic [31:0] rd_q[$];
    logic [29:0] log_addr[$];
    logic [31:0] log_data[$];
    logic        log_we[$];
    int          unstable, req_starts, stb_cycles;
    int          cyc, dly;
    logic [29:0] cur_addr;
    logic [31:0] cur_data;
    logic        cur_we;

    // run_cmd results
    int nbusy, ndone, first_done;
    bit finished;

    function automatic logic [29:0] exp_addr(logic [29:0] b, int i);
        return {b[29:2], 2'b00} + 30'(4 * i);
    endfunction

    task automatic clear_logs();
        log_addr.delete(); log_data.delete(); log_we.delete(); rd_q.delete();
        unstable = 0; req_starts = 0; stb_cycles = 0;
    endtask

    // Bus-bridge responder: acks after dly strobe cycles, logs each transfer
    initial begin
        ext_acknowledge = 1'b0;
        ext_read_data = '0;
        cyc = 0;
        forever begin
            @(negedge clk_clk);
            if (!reset_reset_n || ext_acknowledge) begin
                ext_acknowledge = 1'b0;
                cyc = 0;
            end else if (ext_read || ext_write) begin
                if (ext_read && ext_write) unstable++;
                if (ext_byte_enable !== 4'hF) unstable++;
                if (cyc == 0) begin
                    cur_addr = ext_address; cur_data = ext_write_data;
                    cur_we = ext_write; req_starts++;
                    dly = (dly_fixed >= 0) ? dly_fixed : int'($urandom_range(0, 6));
                end else if (ext_address !== cur_addr || ext_write_data !== cur_data
                             || ext_write !== cur_we) begin
                    unstable++;
                end
                stb_cycles++;
                cyc++;
                if (!noack && cyc > dly) begin
                    ext_acknowledge = 1'b1;
                    log_addr.push_back(cur_addr);
                    log_data.push_back(cur_data);
                    log_we.push_back(cur_we);
                    if (!cur_we) ext_read_data = (rd_q.size() > 0) ? rd_q.pop_front() : 32'd0;
                end
            end else begin
                cyc = 0;
                if (ext_byte_enable !== 4'h0) unstable++;
            end
        end
    end

    task automatic run_cmd(input logic m, input logic [29:0] b, input logic [15:0] n,
                           input logic [31:0] s, input int inject_at);
        int c;
        nbusy = 0; ndone = 0; first_done = -1; finished = 1'b0;
        @(negedge clk_clk);
        start = 1'b1; mode = m; base_addr = b; word_count = n; seed = s;
        @(negedge clk_clk);
        c = 1;
        while (c < 3000) begin
            start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
            if (c == inject_at) begin
                start = 1'b1; mode = ~m; base_addr = b + 30'h40;
                word_count = 16'd9; seed = ~s;
            end
            if (first_done >= 0 && c >= first_done + 2) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk_clk);
            c++;
        end
        start = 1'b0;
        if (!finished) begin
            n_total++;
            $display("FAIL run_cmd: no done pulse within %0d cycles", c);
        end
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0; start = 1'b0; mode = 1'b0;
        base_addr = '0; word_count = '0; seed = '0;
        repeat (3) @(negedge clk_clk);
        n_total++;
        if ({ext_read, ext_write, busy, done} !== 4'b0000)
            $display("FAIL reset_strobes: got %b expected 0000", {ext_read, ext_write, busy, done});
        else n_pass++;
        n_total++;
        if ({ext_address, ext_byte_enable, ext_write_data, timeout_err, err_count, first_err_addr} !== '0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {ext_address, ext_byte_enable, ext_write_data, timeout_err, err_count, first_err_addr});
        else n_pass++;
        reset_reset_n = 1'b1;
    endtask

    task automatic test_fill();
        clear_logs(); dly_fixed = 0;
        run_cmd(1'b0, 30'h100, 16'd3, 32'hA0, 0);
        n_total++;
        if (log_addr.size() !== 3) $display("FAIL fill_count: got %0d expected 3", log_addr.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            n_total++;
            if ({log_addr[i], log_data[i], log_we[i]} !== {exp_addr(30'h100, i), 32'hA0 + 32'(i), 1'b1})
                $display("FAIL fill_word%0d: got %h/%h expected %h/%h", i, log_addr[i], log_data[i],
                         exp_addr(30'h100, i), 32'hA0 + 32'(i));
            else n_pass++;
        end
        n_total++;
        if (nbusy !== 6 || ndone !== 1 || first_done !== 7)
            $display("FAIL fill_timing: got busy=%0d done=%0d at=%0d expected 6/1/7", nbusy, ndone, first_done);
        else n_pass++;
        n_total++;
        if ({err_count, timeout_err, unstable} !== {16'd0, 1'b0, 32'd0})
            $display("FAIL fill_status: got err=%0d tmo=%0b unst=%0d expected 0/0/0", err_count, timeout_err, unstable);
        else n_pass++;
    endtask

    task automatic test_verify_mismatch();
        clear_logs(); dly_fixed = 0;
        rd_q = '{32'hA0, 32'hFF, 32'hA2};
        run_cmd(1'b1, 30'h100, 16'd3, 32'hA0, 0);
        n_total++;
        if (err_count !== 16'd1) $display("FAIL verify_errcnt: got %0d expected 1", err_count);
        else n_pass++;
        n_total++;
        if (first_err_addr !== 30'h104) $display("FAIL verify_firsterr: got %h expected 104", first_err_addr);
        else n_pass++;
        n_total++;
        if (timeout_err !== 1'b0 || log_addr.size() !== 3 || nbusy !== 6)
            $display("FAIL verify_run: got tmo=%0b n=%0d busy=%0d expected 0/3/6", timeout_err, log_addr.size(), nbusy);
        else n_pass++;
        n_total++;
        if (log_we.size() == 3 && (log_we[0] | log_we[1] | log_we[2]) !== 1'b0)
            $display("FAIL verify_reads: got write strobe expected reads only");
        else n_pass++;
    endtask

    task automatic test_wait_wrap();
        logic [31:0] s;
        clear_logs(); dly_fixed = 5; s = $urandom;
        run_cmd(1'b0, 30'h3FFFFFFC, 16'd2, s, 0);
        n_total++;
        if (log_addr.size() !== 2 || log_addr[0] !== 30'h3FFFFFFC || log_addr[1] !== 30'h0)
            $display("FAIL wrap_addr: got n=%0d expected 3FFFFFFC then 0", log_addr.size());
        else n_pass++;
        n_total++;
        if (stb_cycles !== 12 || unstable !== 0 || nbusy !== 14)
            $display("FAIL wait_stable: got stb=%0d unst=%0d busy=%0d expected 12/0/14", stb_cycles, unstable, nbusy);
        else n_pass++;
        n_total++;
        if (log_data.size() == 2 && log_data[1] !== s + 32'd1)
            $display("FAIL wrap_data: got %h expected %h", log_data[1], s + 32'd1);
        else n_pass++;
    endtask

    task automatic test_timeout();
        clear_logs(); noack = 1'b1;
        run_cmd(1'b0, 30'h200, 16'd3, 32'h5, 0);
        noack = 1'b0;
        n_total++;
        if (stb_cycles !== 8 || req_starts !== 1 || log_addr.size() !== 0)
            $display("FAIL timeout_strobe: got stb=%0d reqs=%0d acks=%0d expected 8/1/0", stb_cycles, req_starts, log_addr.size());
        else n_pass++;
        n_total++;
        if (timeout_err !== 1'b1 || ndone !== 1 || first_done !== 9)
            $display("FAIL timeout_flag: got tmo=%0b done=%0d at=%0d expected 1/1/9", timeout_err, ndone, first_done);
        else n_pass++;
    endtask

    task automatic test_zero_and_busy();
        clear_logs(); dly_fixed = 0;
        run_cmd(1'b0, 30'h300, 16'd0, 32'h1, 1);
        n_total++;
        if (first_done !== 1 || ndone !== 1 || req_starts !== 0 || timeout_err !== 1'b0)
            $display("FAIL zero_count: got at=%0d done=%0d reqs=%0d tmo=%0b expected 1/1/0/0", first_done, ndone, req_starts, timeout_err);
        else n_pass++;
        clear_logs(); dly_fixed = -1;
        run_cmd(1'b0, 30'h400, 16'd4, 32'h77, 3);
        n_total++;
        if (log_addr.size() !== 4 || ndone !== 1) $display("FAIL busy_start: got n=%0d done=%0d expected 4/1", log_addr.size(), ndone);
        else n_pass++;
        for (int i = 0; i < log_addr.size(); i++) begin
            n_total++;
            if ({log_addr[i], log_data[i], log_we[i]} !== {exp_addr(30'h400, i), 32'h77 + 32'(i), 1'b1})
                $display("FAIL busy_word%0d: got %h/%h expected %h/%h", i, log_addr[i], log_data[i],
                         exp_addr(30'h400, i), 32'h77 + 32'(i));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic        m;
        logic [29:0] b;
        logic [15:0] n;
        logic [31:0] s, v;
        int          e_err, bad;
        logic [29:0] e_first;
        for (int it = 0; it < 25; it++) begin
            clear_logs(); dly_fixed = -1;
            m = 1'($urandom); b = 30'($urandom); s = $urandom;
            n = 16'($urandom_range(1, 6));
            e_err = 0; e_first = '0;
            for (int i = 0; i < int'(n); i++) begin
                v = s + 32'(i);
                if ($urandom_range(0, 2) == 0) begin
                    v = v ^ ($urandom | 32'd1);
                    if (m) begin
                        if (e_err == 0) e_first = exp_addr(b, i);
                        e_err++;
                    end
                end
                rd_q.push_back(v);
            end
            if (!m) rd_q.delete();
            run_cmd(m, b, n, s, 0);
            bad = (log_addr.size() != int'(n)) ? 1 : 0;
            for (int i = 0; i < log_addr.size(); i++)
                if (log_addr[i] !== exp_addr(b, i) || log_we[i] !== !m || (!m && log_data[i] !== s + 32'(i)))
                    bad++;
            n_total++;
            if (bad != 0 || unstable != 0)
                $display("FAIL rand%0d_txns: got bad=%0d unst=%0d expected 0/0", it, bad, unstable);
            else n_pass++;
            n_total++;
            if (err_count !== 16'(e_err) || first_err_addr !== e_first || timeout_err !== 1'b0)
                $display("FAIL rand%0d_errs: got %0d/%h expected %0d/%h", it, err_count, first_err_addr, e_err, e_first);
            else n_pass++;
            n_total++;
            if (nbusy !== stb_cycles + int'(n) || ndone !== 1)
                $display("FAIL rand%0d_busy: got %0d expected %0d", it, nbusy, stb_cycles + int'(n));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int w;
        clear_logs(); dly_fixed = 3;
        @(negedge clk_clk);
        start = 1'b1; mode = 1'b0; base_addr = 30'h500; word_count = 16'd5; seed = 32'h9;
        @(negedge clk_clk);
        start = 1'b0;
        w = 0;
        while (!ext_write && w < 20) begin
            @(negedge clk_clk);
            w++;
        end
        n_total++;
        if (!ext_write) $display("FAIL rstmid_wait: got no write strobe expected one");
        else n_pass++;
        #2 reset_reset_n = 1'b0;
        #1;
        n_total++;
        if ({ext_address, ext_byte_enable, ext_read, ext_write, ext_write_data, busy, done,
             timeout_err, err_count, first_err_addr} !== '0)
            $display("FAIL rstmid_outputs: got write=%0b busy=%0b addr=%h expected all 0", ext_write, busy, ext_address);
        else n_pass++;
        @(negedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        clear_logs(); dly_fixed = 0;
        run_cmd(1'b0, 30'h600, 16'd2, 32'h33, 0);
        n_total++;
        if (log_addr.size() !== 2 || log_addr[0] !== 30'h600 || log_data[1] !== 32'h34 || nbusy !== 4)
            $display("FAIL rstmid_resume: got n=%0d busy=%0d expected 2/4", log_addr.size(), nbusy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_verify_mismatch();
        test_wait_wrap();
        test_timeout();
        test_zero_and_busy();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ext_bus_master_seq.md
EXT_BUS_MASTER_SEQ -- requirements
Module: ext_bus_master_seq

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1023, max clock cycles a request may wait for acknowledge (1..65535).
REQ-002 clk_clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset_reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle command strobe; ignored while busy=1.
REQ-005 mode  input  1  0 = fill (write), 1 = verify (read and compare); sampled with start.
REQ-006 base_addr  input  30  byte start address; sampled with start; bits [1:0] ignored.
REQ-007 word_count  input  16  number of 32-bit words; sampled with start.
REQ-008 seed  input  32  pattern seed; sampled with start.
REQ-009 ext_address  output  30  byte address to the external-bus-to-Avalon bridge; bits [1:0] always 0.
REQ-010 ext_byte_enable  output  4  always 4'hF during a request, 4'h0 otherwise.
REQ-011 ext_read / ext_write  output  1 each  request strobes, never both high.
REQ-012 ext_write_data  output  32  write data, valid while ext_write=1.
REQ-013 ext_acknowledge  input  1  bridge completion; valid only while a request is high.
REQ-014 ext_read_data  input  32  read data, valid in the ext_acknowledge cycle of a read.
REQ-015 busy  output  1  command in progress.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 timeout_err  output  1  sticky until next accepted start; last command aborted on timeout.
REQ-018 err_count  output  16  verify mismatches in last command, saturating at 16'hFFFF.
REQ-019 first_err_addr  output  30  address of first mismatch in last command; 0 if none.

Function
REQ-020 FSM states IDLE, ISSUE, GAP, DONE; IDLE -> ISSUE on start with word_count!=0; IDLE -> DONE on start with word_count==0.
REQ-021 Accepting start clears err_count, first_err_addr and timeout_err, and loads word index i=0.
REQ-022 Latency: start sampled at edge N -> busy and request strobe high from cycle N+1.
REQ-023 Word i address = {base_addr[29:2],2'b00} + 4*i, modulo 2^30 (wraps silently past 30'h3FFFFFFC).
REQ-024 Word i pattern = seed + i, 32-bit modulo; fill writes it, verify compares ext_read_data against it.
REQ-025 ISSUE: strobe, address, byte_enable and write_data held stable until ext_acknowledge is sampled high.
REQ-026 On ext_acknowledge sampled high: capture/compare read data at that edge, deassert the strobe the next cycle, go to GAP.
REQ-027 GAP: one cycle with both strobes low; increment i; if i == word_count go to DONE, else go to ISSUE.
REQ-028 Throughput: ack in the first request cycle gives 2 cycles per word.
REQ-029 Mismatch: err_count increments (saturating); first_err_addr loads only on the first mismatch.
REQ-030 Timeout: wait counter clears on entry to ISSUE; reaching TIMEOUT_CYCLES without ack deasserts the strobe, sets timeout_err, goes to DONE, and issues no further words.
REQ-031 DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
REQ-032 An ext_acknowledge outside ISSUE is ignored.
REQ-033 start asserted while busy=1 or in DONE has no effect.

Reset
REQ-034 Assertion of reset_reset_n=0 immediately forces IDLE.
REQ-035 Reset drives all outputs to 0, including ext_read/ext_write, busy, done, err_count, first_err_addr and timeout_err.
REQ-036 Reset mid-transfer abandons the request without waiting for ext_acknowledge.
REQ-037 Operation resumes on the first rising edge after deassertion, with start accepted from that edge.

Verification
REQ-038 Fill: base 30'h100, count 3, seed 32'hA0, ack in 1st cycle -> writes (100,A0),(104,A1),(108,A2), 6 busy cycles, one done pulse.
REQ-039 Verify with injected mismatch: same command, mode 1, responder returns A0,FF,A2 -> err_count=1, first_err_addr=30'h104, timeout_err=0.
REQ-040 Wait states and wrap: ack delayed 5 cycles, base 30'h3FFFFFFC, count 2 -> strobe and address stable 6 cycles; addresses 3FFFFFFC then 0.
REQ-041 Timeout: TIMEOUT_CYCLES=8, no ack -> strobe drops after 8 cycles, timeout_err=1, done pulse, no second word.
REQ-042 Zero count and busy start: count 0 -> done pulse 1 cycle after start, no strobe; start during a run -> ignored.
REQ-043 Reset mid-run: reset_reset_n low while ext_write=1 -> all outputs 0 at once; a new start after release runs normally.
